// File: rtl/score_pkg.sv
// Shared types and constants for the score-to-BCD conversion path.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    // Shown on every digit when the score does not fit the display.
    localparam logic [3:0] BCD_SAT = 4'h9;

    // 10^n at 64 bits. Callers resize it to their own comparison width.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: digit_in  - BCD nibble before the correction step
//        digit_out - nibble after the correction, ready to be shifted left
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/score_bcd_converter.sv
// Serial binary-to-BCD converter (shift-add-3) feeding the HEX display decoders.
// Latency: done and new bcd_out appear BIN_WIDTH+1 cycles after start is accepted.
// Backpressure: none; start is accepted only in IDLE and dropped while busy.
// Ports: clk, resetN (synchronous, active low)
//        start, score_in        - conversion request and the value to convert
//        busy, done, overflow   - status; done pulses for one cycle per conversion
//        bcd_out                - packed digits, digit 0 in bits [3:0], held between conversions
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  score_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    // Wide enough for both the score and 10^DIGITS, so the limit never truncates.
    localparam int CMP_W = ((BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W) + 1;
    localparam logic [CMP_W-1:0] OVF_LIMIT = CMP_W'(pow10(DIGITS));

    bcd_state_t         state;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_pend;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shifted;
    logic               ovf_now;

    // All digits are corrected from their pre-adjust values in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (sr[BIN_WIDTH + 4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    assign sr_adj     = {bcd_adj, sr[BIN_WIDTH-1:0]};
    assign sr_shifted = sr_adj << 1;
    assign ovf_now    = (CMP_W'(score_in) >= OVF_LIMIT);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr       <= {{BCD_W{1'b0}}, score_in};
                        bit_cnt  <= '0;
                        ovf_pend <= ovf_now;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= sr_shifted;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    // Outputs are loaded on the final shift so they are
                    // registered and visible during the DONE cycle itself.
                    if (bit_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        overflow <= ovf_pend;
                        bcd_out  <= ovf_pend ? {DIGITS{BCD_SAT}}
                                             : sr_shifted[SR_W-1 -: BCD_W];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: default instance plus a DIGITS=4 instance.
// Expected digits come from a decimal model pushed at stimulus time, popped on done.
module tb_score_bcd_converter;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        resetN;

    logic        start0;
    logic [15:0] score0;
    logic        busy0, done0, ovf0;
    logic [19:0] bcd0;

    logic        start1;
    logic [15:0] score1;
    logic        busy1, done1, ovf1;
    logic [15:0] bcd1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   dones0 = 0;

    score_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5)) u_dut0 (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start0),
        .score_in (score0),
        .busy     (busy0),
        .done     (done0),
        .overflow (ovf0),
        .bcd_out  (bcd0)
    );

    score_bcd_converter #(.BIN_WIDTH(16), .DIGITS(4)) u_dut1 (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start1),
        .score_in (score1),
        .busy     (busy1),
        .done     (done1),
        .overflow (ovf1),
        .bcd_out  (bcd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int d);
        exp_t e;
        int   lim;
        int   x;
        lim   = 1;
        x     = v;
        e.bcd = '0;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e.ovf = (v >= lim);
        for (int i = 0; i < d; i++) begin
            if (e.ovf) begin
                e.bcd[4*i +: 4] = 4'h9;
            end else begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return e;
    endfunction

    // Step n clock edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboards: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            dones0++;
            if (q0.size() == 0) begin
                chk("spurious_done0", 32'(done0), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("bcd0", 32'(bcd0), e.bcd);
                chk("ovf0", 32'(ovf0), 32'(e.ovf));
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("spurious_done1", 32'(done1), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("bcd1", 32'(bcd1), e.bcd);
                chk("ovf1", 32'(ovf1), 32'(e.ovf));
            end
        end
    end

    task automatic wait_idle0();
        int t = 0;
        while ((busy0 !== 1'b0 || q0.size() != 0) && t < 60) begin
            tick(1);
            t++;
        end
        chk("wait0_bound", 32'(t < 60), 32'd1);
    endtask

    task automatic wait_idle1();
        int t = 0;
        while ((busy1 !== 1'b0 || q1.size() != 0) && t < 60) begin
            tick(1);
            t++;
        end
        chk("wait1_bound", 32'(t < 60), 32'd1);
    endtask

    task automatic convert0(input int v);
        score0 = 16'(v);
        start0 = 1'b1;
        q0.push_back(model(v, 5));
        tick(1);
        start0 = 1'b0;
        wait_idle0();
    endtask

    task automatic convert1(input int v);
        score1 = 16'(v);
        start1 = 1'b1;
        q1.push_back(model(v, 4));
        tick(1);
        start1 = 1'b0;
        wait_idle1();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before;
        resetN = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        score0 = '0;
        score1 = '0;

        // Reset, then idle with no start.
        tick(2);
        resetN = 1'b1;
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_ovf0",  32'(ovf0),  32'd0);
        chk("rst_bcd0",  32'(bcd0),  32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_bcd1",  32'(bcd1),  32'd0);
        tick(5);
        chk("idle_busy0", 32'(busy0), 32'd0);
        chk("idle_bcd0",  32'(bcd0),  32'd0);

        // Cycle-exact busy/done for a conversion of 0.
        score0 = 16'd0;
        start0 = 1'b1;
        q0.push_back(model(0, 5));
        tick(1);
        start0 = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            chk($sformatf("busy_c%0d", k), 32'(busy0), 32'(k <= 17));
            chk($sformatf("done_c%0d", k), 32'(done0), 32'(k == 17));
            tick(1);
        end
        wait_idle0();

        convert0(65535);
        convert0(1234);
        convert0(9);
        convert0(10);

        // Starts in cycles 5 and 17 are ignored; cycle 18 is accepted.
        d_before = dones0;
        score0 = 16'd100;
        start0 = 1'b1;
        q0.push_back(model(100, 5));
        tick(1);
        start0 = 1'b0;
        tick(4);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(11);
        chk("ign_done_c17", 32'(done0), 32'd1);
        start0 = 1'b1;
        tick(1);
        chk("ign_busy_c18", 32'(busy0), 32'd0);
        score0 = 16'd250;
        q0.push_back(model(250, 5));
        tick(1);
        start0 = 1'b0;
        chk("ign_busy_c19", 32'(busy0), 32'd1);
        wait_idle0();
        chk("ign_done_count", 32'(dones0 - d_before), 32'd2);

        // Start held high: back-to-back conversions 18 cycles apart.
        score0 = 16'd9;
        start0 = 1'b1;
        q0.push_back(model(9, 5));
        tick(1);
        score0 = 16'd10;
        q0.push_back(model(10, 5));
        for (int k = 1; k <= 36; k++) begin
            chk($sformatf("b2b_done_c%0d", k), 32'(done0), 32'(k == 17 || k == 35));
            if (k == 19) start0 = 1'b0;
            tick(1);
        end
        wait_idle0();

        // Reset in cycle 8 of a conversion of 777 aborts it.
        score0 = 16'd777;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(7);
        resetN = 1'b0;
        tick(1);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_bcd",  32'(bcd0),  32'd0);
        chk("abort_ovf",  32'(ovf0),  32'd0);
        resetN = 1'b1;
        tick(20);
        chk("abort_quiet_busy", 32'(busy0), 32'd0);
        convert0(777);

        // DIGITS=4 instance: saturation and overflow boundaries.
        convert1(12345);
        tick(3);
        chk("ovf1_held", 32'(ovf1), 32'd1);
        chk("bcd1_held", 32'(bcd1), 32'h9999);
        convert1(42);
        convert1(10000);
        convert1(9999);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
